// File: rtl/decoder_pkg.sv
// Shared decoder/encoder definitions: FSM state encoding and the reserved
// zero values used as end-of-sequence token and word terminator.
package decoder_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TFETCH,
    S_TCHECK,
    S_VSEEK,
    S_VCOPY,
    S_WSEP,
    S_WTERM,
    S_DONE,
    S_ERR
  } decoder_state_e;

  localparam int unsigned EOS_TOKEN = 0;
  localparam int unsigned WORD_TERM = 0;

  // States in which a start pulse is honoured.
  function automatic logic is_restart_state(decoder_state_e s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
  endfunction

endpackage

// File: rtl/decoder_vocab_locator.sv
// Walks the packed vocab RAM from address 0 counting terminators until the
// k-th word start is reached; flags failure if the end of the RAM is examined first.
module vocab_locator
  import decoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_k,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ADDR_WIDTH-1:0] o_word_start,
  output logic                  o_found,
  output logic                  o_fail
);

  localparam logic [DATA_WIDTH-1:0] TERM_B = DATA_WIDTH'(WORD_TERM);

  // Extra MSB marks that the last RAM byte is the one being examined.
  logic [ADDR_WIDTH:0]   r_addr;
  logic [DATA_WIDTH-1:0] r_k;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_word_start;
  logic                  r_busy;
  logic                  r_primed;

  assign o_addr       = r_addr[ADDR_WIDTH-1:0];
  assign o_word_start = r_word_start;
  assign o_found      = r_busy && (r_cnt == r_k);
  assign o_fail       = r_busy && !o_found && r_addr[ADDR_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_k          <= '0;
      r_cnt        <= '0;
      r_word_start <= '0;
      r_busy       <= 1'b0;
      r_primed     <= 1'b0;
    end else if (i_start) begin
      r_addr       <= '0;
      r_k          <= i_k;
      r_cnt        <= DATA_WIDTH'(1);
      r_word_start <= '0;
      r_busy       <= 1'b1;
      r_primed     <= 1'b0;
    end else if (r_busy) begin
      if (o_found || o_fail) begin
        r_busy <= 1'b0;
      end else begin
        r_addr   <= r_addr + (ADDR_WIDTH+1)'(1);
        r_primed <= 1'b1;
        // i_dout holds the byte at r_addr-1, so the next word starts at r_addr.
        if (r_primed && (i_dout == TERM_B)) begin
          r_cnt        <= r_cnt + DATA_WIDTH'(1);
          r_word_start <= r_addr[ADDR_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/decoder.sv
// Token-to-text decoder: looks each token up in the packed vocab RAM and writes
// the words, space separated and zero terminated, into the output RAM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for cs
// S_TFETCH | token address presented to token RAM
// S_TCHECK | token byte evaluated: EOS, wrap error, or start vocab seek
// S_VSEEK  | vocab_locator counting terminators up to the k-th word
// S_VCOPY  | streaming word bytes into the output RAM
// S_WSEP   | writing the separator before a non-first word
// S_WTERM  | writing the final zero byte
// S_DONE   | finished, done held until cs
// S_ERR    | failed, error held until cs
module decoder
  import decoder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SEP        = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  output logic [ADDR_WIDTH-1:0] tok_addr,
  input  logic [DATA_WIDTH-1:0] tok_dout,
  output logic [ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0] voc_dout,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  out_we,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [DATA_WIDTH-1:0] TERM_B    = DATA_WIDTH'(WORD_TERM);
  localparam logic [DATA_WIDTH-1:0] EOS_B     = DATA_WIDTH'(EOS_TOKEN);

  decoder_state_e        r_state;
  decoder_state_e        w_next;
  logic [ADDR_WIDTH-1:0] r_tok_ptr;
  logic [ADDR_WIDTH-1:0] r_out_ptr;
  logic [ADDR_WIDTH:0]   r_voc_ptr;
  logic                  r_cprimed;
  logic                  r_first_word;
  logic                  w_start;
  logic                  w_out_full;
  logic                  w_loc_start;
  logic                  w_loc_found;
  logic                  w_loc_fail;
  logic [ADDR_WIDTH-1:0] w_loc_addr;
  logic [ADDR_WIDTH-1:0] w_loc_word_start;

  vocab_locator #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_locator (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_loc_start),
    .i_k         (tok_dout),
    .i_dout      (voc_dout),
    .o_addr      (w_loc_addr),
    .o_word_start(w_loc_word_start),
    .o_found     (w_loc_found),
    .o_fail      (w_loc_fail)
  );

  assign w_start    = cs && is_restart_state(r_state);
  assign w_out_full = (r_out_ptr == ADDR_LAST);
  assign tok_addr   = r_tok_ptr;
  assign out_addr   = r_out_ptr;
  assign voc_addr   = (r_state == S_VCOPY) ? r_voc_ptr[ADDR_WIDTH-1:0] : w_loc_addr;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);

  always_comb begin
    w_next      = r_state;
    out_we      = 1'b0;
    out_din     = '0;
    w_loc_start = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start) w_next = S_TFETCH;
      S_TFETCH: w_next = S_TCHECK;
      S_TCHECK: begin
        if (tok_dout == EOS_B) begin
          w_next = S_WTERM;
        end else if (r_tok_ptr == ADDR_LAST) begin
          w_next = S_ERR;
        end else begin
          w_next      = S_VSEEK;
          w_loc_start = 1'b1;
        end
      end
      S_VSEEK: begin
        if (w_loc_found)     w_next = r_first_word ? S_VCOPY : S_WSEP;
        else if (w_loc_fail) w_next = S_ERR;
      end
      S_WSEP: begin
        if (w_out_full) begin
          w_next = S_ERR;
        end else begin
          out_we  = 1'b1;
          out_din = SEP;
          w_next  = S_VCOPY;
        end
      end
      S_VCOPY: begin
        // First VCOPY cycle only presents the word start; data follows a cycle later.
        if (r_cprimed) begin
          if (voc_dout == TERM_B) begin
            w_next = S_TFETCH;
          end else if (r_voc_ptr[ADDR_WIDTH] || w_out_full) begin
            w_next = S_ERR;
          end else begin
            out_we  = 1'b1;
            out_din = voc_dout;
          end
        end
      end
      S_WTERM: begin
        out_we  = 1'b1;
        out_din = TERM_B;
        w_next  = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tok_ptr    <= '0;
      r_out_ptr    <= '0;
      r_voc_ptr    <= '0;
      r_cprimed    <= 1'b0;
      r_first_word <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start) begin
            r_tok_ptr    <= '0;
            r_out_ptr    <= '0;
            r_first_word <= 1'b1;
          end
        end
        S_TCHECK: if (w_loc_start) r_tok_ptr <= r_tok_ptr + ADDR_WIDTH'(1);
        S_VSEEK: begin
          if (w_loc_found) begin
            r_voc_ptr <= {1'b0, w_loc_word_start};
            r_cprimed <= 1'b0;
          end
        end
        S_WSEP: if (out_we) r_out_ptr <= r_out_ptr + ADDR_WIDTH'(1);
        S_VCOPY: begin
          if (!r_cprimed) begin
            r_voc_ptr <= r_voc_ptr + (ADDR_WIDTH+1)'(1);
            r_cprimed <= 1'b1;
          end else if (out_we) begin
            r_voc_ptr    <= r_voc_ptr + (ADDR_WIDTH+1)'(1);
            r_out_ptr    <= r_out_ptr + ADDR_WIDTH'(1);
            r_first_word <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: RAM models, a list-level reference model of the decoded
// output, a per-cycle write checker, directed scenarios and random vocab/token sets.
module tb_decoder;

  localparam logic [7:0] SEP_B = 8'h20;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic [3:0] tok_addr;
  logic [7:0] tok_dout;
  logic [3:0] voc_addr;
  logic [7:0] voc_dout;
  logic [3:0] out_addr;
  logic [7:0] out_din;
  logic       out_we;
  logic       done;
  logic       error;

  logic [7:0] tok_mem [16];
  logic [7:0] voc_mem [16];
  logic [7:0] out_mem [16];

  logic [7:0] exp_wr [$];
  bit         exp_err;
  int         wr_idx;
  bit         chk_en;
  int         n_tests;
  int         n_fail;

  decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SEP(8'h20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .tok_addr(tok_addr),
    .tok_dout(tok_dout),
    .voc_addr(voc_addr),
    .voc_dout(voc_dout),
    .out_addr(out_addr),
    .out_din (out_din),
    .out_we  (out_we),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    tok_dout <= tok_mem[tok_addr];
    voc_dout <= voc_mem[voc_addr];
    if (out_we) out_mem[out_addr] <= out_din;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk tokens in order, find the k-th word by counting zeros,
  // emit separator/bytes into a 15-entry data area, then the terminator.
  task automatic build_model();
    int  k;
    int  start;
    int  zeros;
    bit  first;
    exp_wr.delete();
    exp_err = 0;
    first   = 1;
    for (int i = 0; i < 16; i++) begin
      k = int'(tok_mem[i]);
      if (k == 0) begin
        exp_wr.push_back(8'h00);
        return;
      end
      if (i == 15) begin
        exp_err = 1;
        return;
      end
      start = -1;
      if (k == 1) start = 0;
      else begin
        zeros = 0;
        for (int p = 0; p < 15; p++) begin
          if (voc_mem[p] == 8'h00) begin
            zeros++;
            if (zeros == k - 1) begin
              start = p + 1;
              break;
            end
          end
        end
      end
      if (start < 0) begin
        exp_err = 1;
        return;
      end
      if (!first) begin
        if (exp_wr.size() == 15) begin
          exp_err = 1;
          return;
        end
        exp_wr.push_back(SEP_B);
      end
      for (int p = start; p < 16; p++) begin
        if (voc_mem[p] == 8'h00) break;
        if (p == 15 || exp_wr.size() == 15) begin
          exp_err = 1;
          return;
        end
        exp_wr.push_back(voc_mem[p]);
        first = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && out_we) begin
      if (wr_idx < exp_wr.size()) begin
        check("wr_addr", 32'(out_addr), 32'(wr_idx));
        check("wr_data", 32'(out_din), 32'(exp_wr[wr_idx]));
      end else begin
        check("wr_count", 32'(wr_idx + 1), 32'(exp_wr.size()));
      end
      wr_idx++;
    end
  end

  task automatic load_std_vocab();
    logic [7:0] v [16];
    v = '{8'h68, 8'h69, 8'h00, 8'h79, 8'h6F, 8'h00, 8'h6F, 8'h6B, 8'h00,
          8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h2A};
    for (int i = 0; i < 16; i++) voc_mem[i] = v[i];
  endtask

  task automatic set_tokens(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] t2);
    for (int i = 0; i < 16; i++) tok_mem[i] = 8'h00;
    tok_mem[0] = t0;
    tok_mem[1] = t1;
    tok_mem[2] = t2;
  endtask

  task automatic run_case(input int glitch_at, output int cycles);
    build_model();
    wr_idx = 0;
    chk_en = 1;
    @(negedge clk) cs = 1'b1;
    @(negedge clk) cs = 1'b0;
    cycles = 0;
    while (!(done || error) && cycles < 1000) begin
      @(negedge clk);
      cycles++;
      cs = (cycles == glitch_at);
    end
    cs = 1'b0;
    check("finished", 32'(done || error), 32'd1);
    repeat (3) @(negedge clk);
    check("done", 32'(done), 32'(!exp_err));
    check("error", 32'(error), 32'(exp_err));
    check("nwrites", 32'(wr_idx), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++) check("out_mem", 32'(out_mem[i]), 32'(exp_wr[i]));
    chk_en = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tok_addr"}, 32'(tok_addr), 32'd0);
    check({tag, "_voc_addr"}, 32'(voc_addr), 32'd0);
    check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    check({tag, "_out_din"}, 32'(out_din), 32'd0);
    check({tag, "_out_we"}, 32'(out_we), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0] lit033 [6];
    int         cyc;
    int         len;
    lit033  = '{8'h79, 8'h6F, 8'h20, 8'h68, 8'h69, 8'h00};
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 0;
    wr_idx  = 0;
    cs      = 1'b0;
    rst_n   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tok_mem[i] = 8'h00;
      voc_mem[i] = 8'h00;
    end
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // "hi\0yo\0ok\0", tokens [2,1,0]
    load_std_vocab();
    set_tokens(8'd2, 8'd1, 8'd0);
    run_case(0, cyc);
    check("m033_len", 32'(exp_wr.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check("m033_model", 32'(exp_wr[i]), 32'(lit033[i]));
      check("m033_mem", 32'(out_mem[i]), 32'(lit033[i]));
    end

    // Immediate EOS
    set_tokens(8'd0, 8'd0, 8'd0);
    run_case(0, cyc);
    check("eos_latency_ok", 32'(cyc <= 4), 32'd1);
    check("eos_mem0", 32'(out_mem[0]), 32'h00);

    // Unknown token
    set_tokens(8'd9, 8'd0, 8'd0);
    run_case(0, cyc);
    check("m035_model_err", 32'(exp_err), 32'd1);
    check("m035_out_addr", 32'(out_addr), 32'd0);

    // Output overflow: repeated "ok" without EOS
    for (int i = 0; i < 16; i++) tok_mem[i] = 8'd3;
    run_case(0, cyc);
    check("m036_model_len", 32'(exp_wr.size()), 32'd15);
    check("m036_out_addr", 32'(out_addr), 32'd15);
    check("m036_error", 32'(error), 32'd1);

    // Reset while copying word 2, then decode [3,0]
    set_tokens(8'd2, 8'd1, 8'd0);
    @(negedge clk) cs = 1'b1;
    @(negedge clk) cs = 1'b0;
    cyc = 0;
    while (!out_we && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("m037_reached_copy", 32'(out_we), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("m037_async");
    @(posedge clk);
    #1 check_all_zero("m037_held");
    check("m037_partial0", 32'(out_mem[0]), 32'h79);
    check("m037_partial1", 32'(out_mem[1]), 32'h6B);
    @(negedge clk) rst_n = 1'b1;
    set_tokens(8'd3, 8'd0, 8'd0);
    run_case(0, cyc);
    check("m037_model_len", 32'(exp_wr.size()), 32'd3);
    check("m037_mem0", 32'(out_mem[0]), 32'h6F);
    check("m037_mem1", 32'(out_mem[1]), 32'h6B);
    check("m037_mem2", 32'(out_mem[2]), 32'h00);

    // cs pulsed during the vocab seek is ignored
    set_tokens(8'd2, 8'd1, 8'd0);
    run_case(2, cyc);
    for (int i = 0; i < 6; i++) check("m038_mem", 32'(out_mem[i]), 32'(lit033[i]));

    // Random vocab images and token lists
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 16; p++)
        voc_mem[p] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(97, 122));
      len = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++)
        tok_mem[i] = (i < len) ? 8'($urandom_range(1, 6)) : 8'h00;
      run_case(0, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, address width of token, vocab and output memories.
REQ-002 Parameter DATA_WIDTH, default 8, byte width of all memories.
REQ-003 Parameter SEP, default 8'h20, separator byte written between decoded words.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cs  input  1  start pulse; sampled only in IDLE, DONE, ERR.
REQ-007 tok_addr / tok_dout  output ADDR_WIDTH / input DATA_WIDTH  token RAM read port; dout valid one cycle after addr.
REQ-008 voc_addr / voc_dout  output ADDR_WIDTH / input DATA_WIDTH  vocab RAM read port; same one-cycle latency.
REQ-009 out_addr, out_din, out_we  output ADDR_WIDTH, DATA_WIDTH, 1  output RAM write port; write on clk edge when out_we=1.
REQ-010 done  output  1  sticky completion flag.
REQ-011 error  output  1  sticky failure flag.

Function
REQ-012 Token RAM holds token IDs from address 0; value 0 = end-of-sequence (EOS); k>=1 = k-th vocab word (1-based).
REQ-013 Vocab RAM holds words packed from address 0, each word nonzero bytes terminated by one 0 byte.
REQ-014 States: IDLE, TFETCH, TCHECK, VSEEK, VCOPY, WSEP, WTERM, DONE, ERR.
REQ-015 IDLE/DONE/ERR + cs=1 -> TFETCH; token, output pointers and word counter cleared; done, error cleared.
REQ-016 TFETCH drives tok_addr = token pointer; TCHECK evaluates tok_dout next cycle.
REQ-017 TCHECK: token 0 -> WTERM; token k>=1 -> VSEEK with voc_addr=0, word counter=1; token pointer incremented.
REQ-018 VSEEK streams one vocab byte per clock; each 0 byte while counter<k increments counter; when counter reaches k, next byte is the word start -> VCOPY.
REQ-019 VCOPY streams one byte per clock; each nonzero byte written to out_addr with out_we=1, out_addr then incremented; 0 byte -> TFETCH.
REQ-020 Before the first byte of every word except the first, one SEP byte is written (WSEP, one cycle).
REQ-021 WTERM writes one 0 byte at out_addr, then -> DONE; done=1 on the cycle after the WTERM write.
REQ-022 voc_addr reaching all-ones in VSEEK/VCOPY without the required 0 byte -> ERR (unknown token / unterminated word).
REQ-023 Output write required while out_addr is all-ones and not the WTERM write -> ERR, no wrap, no further writes.
REQ-024 Token pointer wrap (all-ones consumed without EOS) -> ERR.
REQ-025 ERR: error=1, done=0, out_we=0, held until cs or reset.
REQ-026 out_we=0 in every state/cycle not listed above; exactly one write per output byte.
REQ-027 cs asserted outside IDLE/DONE/ERR is ignored.

Reset
REQ-028 rst_n low: state=IDLE; tok_addr, voc_addr, out_addr, out_din, out_we, done, error, counters = 0, immediately.
REQ-029 Reset mid-operation aborts with no further writes; partial output RAM contents are not cleared.

Structure
REQ-030 Shared package holds the decoder_state enum and EOS/terminator constants, shared with the encoder.
REQ-031 One sub-module, vocab_locator, performs REQ-018 seek: inputs k, start; outputs word start address, found, fail.
REQ-032 Memories are instantiated outside decoder; decoder contains only ports to them.

Verification
REQ-033 Vocab "hi\0yo\0ok\0", tokens [2,1,0] -> output "yo hi\0" (79 6F 20 68 69 00), done=1, error=0.
REQ-034 Tokens [0] -> output [00] at address 0, done within 4 cycles of cs, no other writes.
REQ-035 Tokens [9,0] with vocab above -> error=1, done=0, no output bytes written.
REQ-036 ADDR_WIDTH=4, tokens repeating 3 ("ok") until >16 output bytes needed -> error=1 at out_addr=15, no wrap.
REQ-037 rst_n low during VCOPY of token 2 -> all outputs 0 asynchronously; new cs after reset decodes [3,0] to "ok\0".
REQ-038 cs pulsed during VSEEK -> ignored; result identical to REQ-033.
